// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared FSM encoding, default constants and entry admission rule
package parking_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_PASS_TIMEOUT    = 32;
  localparam int SPACE_W             = 10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_CARD = 3'd1,
    ST_OPEN      = 3'd2,
    ST_PASSING   = 3'd3,
    ST_DENY      = 3'd4
  } gate_state_t;

  // University cards need both a free university space and a free space overall.
  function automatic logic entry_refused(input logic               is_uni,
                                         input logic [SPACE_W-1:0] uni_space,
                                         input logic [SPACE_W-1:0] total_space);
    return (total_space == '0) || (is_uni && (uni_space == '0));
  endfunction

endpackage

// File: rtl/parking_gate_controller_if.sv
// rtl/parking_gate_controller_if.sv - card reader, occupancy and gate output bundle
interface parking_gate_controller_if;

  logic                           card_valid;
  logic                           card_is_uni;
  logic                           card_ready;
  logic [parking_pkg::SPACE_W-1:0] uni_vacated_space;
  logic [parking_pkg::SPACE_W-1:0] total_vacated_space;
  logic                           barrier_open;
  logic                           car_event;
  logic                           car_is_uni;
  logic                           deny;

  modport master (
    output card_valid, card_is_uni, uni_vacated_space, total_vacated_space,
    input  card_ready, barrier_open, car_event, car_is_uni, deny
  );

  modport slave (
    input  card_valid, card_is_uni, uni_vacated_space, total_vacated_space,
    output card_ready, barrier_open, car_event, car_is_uni, deny
  );

endinterface

// File: rtl/parking_debounce.sv
// rtl/parking_debounce.sv - level filter accepting a change after CYCLES consecutive samples
module parking_debounce #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(CYCLES) + 1;

  logic [CW-1:0] count;

  // Any sample that agrees with the current level restarts the run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level <= 1'b0;
      count <= '0;
    end else if (raw == level) begin
      count <= '0;
    end else if (count == CW'(CYCLES - 1)) begin
      level <= raw;
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/parking_gate_controller.sv
// rtl/parking_gate_controller.sv - single-lane barrier FSM with card admission and pass timeout
module parking_gate_controller
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int PASS_TIMEOUT    = DEF_PASS_TIMEOUT,
  parameter bit IS_EXIT         = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       arrive_sensor,
  input  logic                       pass_sensor,
  parking_gate_controller_if.slave   bus
);

  localparam int TW = $clog2(PASS_TIMEOUT) + 1;

  gate_state_t   state, next_state;
  logic          arrive_f, pass_f;
  logic          accept;
  logic          uni_q;
  logic          deny_q;
  logic          car_event_c;
  logic [TW-1:0] tmo;

  parking_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_arrive_db (
    .clk   (clk),
    .reset (reset),
    .raw   (arrive_sensor),
    .level (arrive_f)
  );

  parking_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_pass_db (
    .clk   (clk),
    .reset (reset),
    .raw   (pass_sensor),
    .level (pass_f)
  );

  assign accept = (state == ST_WAIT_CARD) && bus.card_valid;

  always_comb begin
    next_state  = state;
    car_event_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arrive_f) next_state = ST_WAIT_CARD;
      end
      ST_WAIT_CARD: begin
        // A card presented in the same cycle the car leaves still wins.
        if (accept) begin
          if (!IS_EXIT && entry_refused(bus.card_is_uni, bus.uni_vacated_space,
                                        bus.total_vacated_space))
            next_state = ST_DENY;
          else
            next_state = ST_OPEN;
        end else if (!arrive_f) begin
          next_state = ST_IDLE;
        end
      end
      ST_OPEN: begin
        if (pass_f)
          next_state = ST_PASSING;
        else if (tmo >= TW'(PASS_TIMEOUT - 1))
          next_state = ST_IDLE;
      end
      ST_PASSING: begin
        if (!pass_f) begin
          next_state  = ST_IDLE;
          car_event_c = 1'b1;
        end
      end
      ST_DENY: begin
        if (!arrive_f) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      uni_q  <= 1'b0;
      deny_q <= 1'b0;
      tmo    <= '0;
    end else begin
      state  <= next_state;
      deny_q <= (state == ST_WAIT_CARD) && (next_state == ST_DENY);
      if (accept) uni_q <= bus.card_is_uni;
      // Held at zero outside OPEN so every OPEN visit starts a fresh window.
      if (state != ST_OPEN)
        tmo <= '0;
      else if (tmo != '1)
        tmo <= tmo + 1'b1;
    end
  end

  assign bus.card_ready   = (state == ST_WAIT_CARD);
  assign bus.barrier_open = (state == ST_OPEN) || (state == ST_PASSING);
  assign bus.car_event    = car_event_c;
  assign bus.car_is_uni   = car_event_c & uni_q;
  assign bus.deny         = deny_q;

endmodule
